// File: rtl/pc_fetch_stage.sv
// Instruction-fetch front end: owns the PC, fetches words from instruction memory
// with one request in flight, and queues {instr, pc, pc+4} for decode.
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t        state;
  logic [31:0]   pc;
  logic [31:0]   req_pc;
  logic [CW-1:0] count;
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [31:0]   buf_instr [DEPTH];
  logic [31:0]   buf_pc    [DEPTH];
  logic [31:0]   buf_pc4   [DEPTH];

  logic grant;
  logic push;
  logic pop;
  logic do_redirect;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Requests only issue with buffer space free, so a push can never overflow.
  assign imem_req    = (state == REQ) && (count < FULL);
  assign imem_addr   = pc;
  assign grant       = imem_req && imem_gnt;
  assign do_redirect = redirect_valid && (state != IDLE);
  assign push        = (state == WAIT) && imem_rvalid && !redirect_valid;
  assign pop         = if_valid && if_ready;

  assign if_valid    = (count != '0);
  assign if_instr    = buf_instr[rptr];
  assign if_pc       = buf_pc[rptr];
  assign if_pc_plus4 = buf_pc4[rptr];

  // Redirect wins over everything; a killed in-flight request is absorbed in DROP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
    end else begin
      case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (grant) begin
            req_pc <= pc;
            pc     <= pc + 32'd4;
            state  <= do_redirect ? DROP : WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid)      state <= REQ;
          else if (do_redirect) state <= DROP;
        end
        DROP: begin
          if (imem_rvalid) state <= REQ;
        end
        default: state <= IDLE;
      endcase
      if (do_redirect) pc <= {redirect_pc[31:2], 2'b00};
    end
  end

  // Circular buffer; a flush simply rewinds both pointers and empties it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      rptr  <= '0;
      wptr  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_instr[i] <= '0;
        buf_pc[i]    <= '0;
        buf_pc4[i]   <= '0;
      end
    end else if (do_redirect) begin
      count <= '0;
      rptr  <= '0;
      wptr  <= '0;
    end else begin
      if (push) begin
        buf_instr[wptr] <= imem_rdata;
        buf_pc[wptr]    <= req_pc;
        buf_pc4[wptr]   <= req_pc + 32'd4;
        wptr            <= next_ptr(wptr);
      end
      if (pop) rptr <= next_ptr(rptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed-vector bench for pc_fetch_stage: reset, streaming, backpressure,
// redirect collisions, PC wrap and asynchronous mid-operation reset.
module tb_pc_fetch_stage;

  localparam logic [31:0] RPC = 32'h0040_0000;
  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  int compared = 0;
  int mismatched = 0;
  logic mem_auto = 1'b0;

  pc_fetch_stage #(.RESET_PC(RPC), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // One clock; with mem_auto set the bench plays a single-cycle memory
  task automatic applyStimulus();
    logic        granted;
    logic [31:0] addr_s;
    granted = imem_req && imem_gnt;
    addr_s  = imem_addr;
    @(posedge clk);
    #1;
    if (mem_auto) begin
      imem_gnt    = 1'b1;
      imem_rvalid = granted;
      imem_rdata  = addr_s ^ KEY;
    end
  endtask

  task automatic resetDut();
    rst = 1'b1;
    mem_auto = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    if_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic expectStream(input int n, input logic [31:0] start_pc);
    int got;
    logic [31:0] exp_pc;
    got = 0;
    for (int cyc = 0; cyc < 40 && got < n; cyc++) begin
      if (if_valid && if_ready) begin
        exp_pc = start_pc + 32'(4 * got);
        checkOutput("stream_pc", if_pc, exp_pc);
        checkOutput("stream_pc4", if_pc_plus4, exp_pc + 32'd4);
        checkOutput("stream_instr", if_instr, exp_pc ^ KEY);
        got++;
      end
      applyStimulus();
    end
    checkOutput("stream_count", 32'(got), 32'(n));
  endtask

  initial begin
    // Reset values while rst is held
    rst = 1'b1;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_req", 32'(imem_req), 32'd0);
    checkOutput("rst_addr", imem_addr, RPC);
    checkOutput("rst_valid", 32'(if_valid), 32'd0);
    checkOutput("rst_instr", if_instr, 32'd0);
    checkOutput("rst_pc", if_pc, 32'd0);
    checkOutput("rst_pc4", if_pc_plus4, 32'd0);

    // Streaming with latency check
    rst = 1'b0;
    checkOutput("c0_req", 32'(imem_req), 32'd0);
    mem_auto = 1'b1; imem_gnt = 1'b1; if_ready = 1'b1;
    applyStimulus();
    checkOutput("c1_req", 32'(imem_req), 32'd1);
    checkOutput("c1_addr", imem_addr, RPC);
    applyStimulus();
    checkOutput("c2_req", 32'(imem_req), 32'd0);
    checkOutput("c2_valid", 32'(if_valid), 32'd0);
    applyStimulus();
    checkOutput("c3_valid", 32'(if_valid), 32'd1);
    expectStream(3, RPC);

    // Backpressure: two entries fill the buffer, fetching stalls
    resetDut();
    mem_auto = 1'b1; imem_gnt = 1'b1; if_ready = 1'b0;
    repeat (10) applyStimulus();
    checkOutput("bp_req", 32'(imem_req), 32'd0);
    checkOutput("bp_valid", 32'(if_valid), 32'd1);
    checkOutput("bp_head", if_pc, RPC);
    checkOutput("bp_addr", imem_addr, RPC + 32'd8);
    if_ready = 1'b1;
    expectStream(3, RPC);

    // Redirect while a response is pending
    resetDut();
    if_ready = 1'b0;
    applyStimulus();
    imem_gnt = 1'b1;
    applyStimulus();
    checkOutput("w_req", 32'(imem_req), 32'd0);
    imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0040_0103;
    applyStimulus();
    redirect_valid = 1'b0;
    checkOutput("w_drop_req", 32'(imem_req), 32'd0);
    checkOutput("w_drop_addr", imem_addr, 32'h0040_0100);
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    applyStimulus();
    imem_rvalid = 1'b0;
    checkOutput("w_stale_valid", 32'(if_valid), 32'd0);
    checkOutput("w_refetch_req", 32'(imem_req), 32'd1);
    checkOutput("w_refetch_addr", imem_addr, 32'h0040_0100);
    imem_gnt = 1'b1;
    applyStimulus();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
    applyStimulus();
    imem_rvalid = 1'b0;
    checkOutput("w_new_valid", 32'(if_valid), 32'd1);
    checkOutput("w_new_instr", if_instr, 32'h1234_5678);
    checkOutput("w_new_pc", if_pc, 32'h0040_0100);
    checkOutput("w_new_pc4", if_pc_plus4, 32'h0040_0104);

    // Redirect colliding with a grant in REQ
    checkOutput("g_req", 32'(imem_req), 32'd1);
    imem_gnt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    applyStimulus();
    imem_gnt = 1'b0; redirect_valid = 1'b0;
    checkOutput("g_flush_valid", 32'(if_valid), 32'd0);
    checkOutput("g_drop_req", 32'(imem_req), 32'd0);
    checkOutput("g_drop_addr", imem_addr, 32'h0000_0200);
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    applyStimulus();
    imem_rvalid = 1'b0;
    checkOutput("g_killed_valid", 32'(if_valid), 32'd0);
    checkOutput("g_refetch_req", 32'(imem_req), 32'd1);
    checkOutput("g_refetch_addr", imem_addr, 32'h0000_0200);

    // Redirect with rvalid in the same WAIT cycle
    imem_gnt = 1'b1;
    applyStimulus();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    applyStimulus();
    imem_rvalid = 1'b0; redirect_valid = 1'b0;
    checkOutput("r_nopush_valid", 32'(if_valid), 32'd0);
    checkOutput("r_req", 32'(imem_req), 32'd1);
    checkOutput("r_addr", imem_addr, 32'hFFFF_FFFC);

    // PC wrap
    imem_gnt = 1'b1;
    applyStimulus();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_F00D;
    applyStimulus();
    imem_rvalid = 1'b0;
    checkOutput("wrap_valid", 32'(if_valid), 32'd1);
    checkOutput("wrap_pc", if_pc, 32'hFFFF_FFFC);
    checkOutput("wrap_pc4", if_pc_plus4, 32'h0000_0000);
    checkOutput("wrap_instr", if_instr, 32'hCAFE_F00D);
    checkOutput("wrap_next_addr", imem_addr, 32'h0000_0000);

    // Asynchronous reset in the middle of WAIT
    imem_gnt = 1'b1;
    applyStimulus();
    imem_gnt = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_req", 32'(imem_req), 32'd0);
    checkOutput("arst_addr", imem_addr, RPC);
    checkOutput("arst_valid", 32'(if_valid), 32'd0);
    checkOutput("arst_instr", if_instr, 32'd0);
    checkOutput("arst_pc", if_pc, 32'd0);
    checkOutput("arst_pc4", if_pc_plus4, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
- Instruction-fetch front end of the MIPS pipeline.
- Owns the program counter and issues word fetches to instruction memory over a request/grant/response handshake.
- Buffers returned instructions with their PC and PC+4 and presents them to decode over a valid/ready interface.
- Its PC+4 output feeds the branch-target and link adders downstream; branch/jump redirects come back from execute.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)
DEPTH, 2, entries in the output buffer (>=1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch byte address (word aligned)
imem_gnt  input  1  memory accepts request this cycle (meaningful only when imem_req=1)
imem_rvalid  input  1  read data valid, in order, >=1 cycle after grant
imem_rdata  input  32  instruction word
redirect_valid  input  1  branch/jump taken, flush and refetch
redirect_pc  input  32  new PC; bits [1:0] ignored (forced 0)
if_valid  output  1  buffer head valid
if_ready  input  1  decode accepts head
if_instr  output  32  head instruction
if_pc  output  32  head PC
if_pc_plus4  output  32  head PC+4, modulo 2^32

Behaviour:
- Reset (async):
  - state=IDLE, pc=RESET_PC, count=0, buffer cleared.
  - Outputs: imem_req=0, imem_addr=RESET_PC, if_valid=0, if_instr/if_pc/if_pc_plus4=0.
  - Instruction memory is reset by the same rst; no pre-reset response ever arrives.
- States: IDLE, REQ, WAIT, DROP. At most one outstanding request.
  - IDLE: first cycle after reset release; imem_req=0; go to REQ.
  - REQ:
    - imem_req = (count<DEPTH); imem_addr = pc.
    - On imem_req&&imem_gnt: req_pc<=pc, pc<=pc+4, go to WAIT.
  - WAIT:
    - imem_req=0.
    - On imem_rvalid: push {imem_rdata, req_pc, req_pc+4}, go to REQ.
  - DROP:
    - imem_req=0; awaits the response of a killed request.
    - On imem_rvalid: discard data, go to REQ.
- Redirect (highest priority, any state except IDLE):
  - Applies: pc<=redirect_pc&~3, buffer flushed (count<=0), so if_valid=0 next cycle.
  - REQ with grant in the same cycle: the granted request is killed; go to DROP.
  - REQ without grant: stay in REQ; the next request uses the new pc.
  - WAIT without rvalid: go to DROP.
  - WAIT with rvalid in the same cycle: data discarded, no push; go to REQ.
  - DROP: pc updated; stay in DROP (or go to REQ if rvalid in the same cycle).
  - A pop handshake in the redirect cycle completes normally (decode owns the kill); then flush.
- Buffer:
  - Circular FIFO of DEPTH entries; head drives if_* combinationally; if_valid = (count!=0).
  - Pop on if_valid&&if_ready.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Overflow impossible: requests issue only when count<DEPTH, and only responses push.
  - Read/write pointers wrap modulo DEPTH.
- Arithmetic:
  - All PC adds are 32-bit unsigned, modulo 2^32; 0xFFFF_FFFC+4 = 0x0000_0000.
  - No exceptions on wrap or misalignment.
- Latency:
  - Grant in cycle N with rvalid in cycle N+1 gives if_valid in cycle N+2.
  - Steady state with gnt=1, single-cycle memory and if_ready=1: one instruction per 2 cycles (single outstanding).
- Mid-operation reset: all state returns to reset values immediately; any in-flight data is lost.

Test Plan:
- Reset: RESET_PC=0x0040_0000, release rst -> cycle 0 imem_req=0; cycle 1 imem_req=1, imem_addr=0x0040_0000.
- Streaming: gnt=1, rvalid 1 cycle after grant, rdata=addr^0xA5A5_A5A5, if_ready=1 -> if_pc sequence 0x0040_0000, 0x0040_0004, 0x0040_0008; if_pc_plus4=if_pc+4; instr matches.
- Backpressure: if_ready=0 -> after 2 entries, imem_req stays 0 and count=2; raise if_ready -> entries drain in order and fetching resumes at 0x0040_0008.
- Redirect in WAIT: redirect_pc=0x0040_0103 while a response is pending -> stale rdata is not pushed, if_valid=0, next imem_addr=0x0040_0100.
- Redirect colliding with grant and rvalid: redirect in a REQ cycle with gnt=1 -> state DROP, next response discarded, then refetch at the redirect target; redirect with rvalid in the same WAIT cycle -> no push, REQ next cycle.
- Wrap: redirect to 0xFFFF_FFFC -> fetch 0xFFFF_FFFC with if_pc_plus4=0x0000_0000; next fetch at 0x0000_0000. Assert rst asynchronously mid-WAIT -> outputs return to reset values within the same cycle.
